mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Tagged main-memory model: accepts loads/stores, returns load {tag,data} in order. Optional MEM_RESP_STALL_EN adds LFSR refusals.
// Latency: response is combinational; load tag/data appear registered exactly LATENCY cycles after acceptance.
// Backpressure: response 0 when no tag is free (or on an LFSR stall); requester holds the command until nonzero.
module mem_responder #(
    parameter int MEM_WORDS       = 4096,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [63:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [63:0]              mem [MEM_WORDS];
    logic [MAX_OUTSTANDING:1] busy;
    logic [MAX_OUTSTANDING:1] busy_next;
    logic [3:0]               pipe_tag  [LATENCY];
    logic [63:0]              pipe_data [LATENCY];
    logic [3:0]               free_tag;
    logic                     stall;
    logic                     accept;
    logic                     load_acc;
    logic                     store_acc;
    logic [AW-1:0]            word_idx;
    logic                     unused_addr_bits;

    assign word_idx         = proc2mem_addr[3 +: AW];
    assign unused_addr_bits = ^{proc2mem_addr[63:3+AW], proc2mem_addr[2:0]};

`ifdef MEM_RESP_STALL_EN
    logic [15:0] lfsr;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign stall = (lfsr[2:0] == 3'b000);
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        free_tag = 4'd0;
        for (int i = MAX_OUTSTANDING; i >= 1; i--) begin
            if (!busy[i]) begin
                free_tag = 4'(i);
            end
        end
    end

    assign accept    = ((proc2mem_command == BUS_LOAD) || (proc2mem_command == BUS_STORE))
                       && (free_tag != 4'd0) && !stall;
    assign load_acc  = accept && (proc2mem_command == BUS_LOAD);
    assign store_acc = accept && (proc2mem_command == BUS_STORE);
    assign mem2proc_response = accept ? free_tag : 4'd0;

    // A returning tag stays busy through its return cycle, so it never collides with a new allocation.
    always_comb begin
        busy_next = busy;
        for (int i = 1; i <= MAX_OUTSTANDING; i++) begin
            if (mem2proc_tag == 4'(i)) begin
                busy_next[i] = 1'b0;
            end
            if (load_acc && (free_tag == 4'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i]  <= 4'd0;
                pipe_data[i] <= 64'd0;
            end
        end else begin
            busy         <= busy_next;
            pipe_tag[0]  <= load_acc ? free_tag : 4'd0;
            pipe_data[0] <= load_acc ? mem[word_idx] : 64'd0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_tag[i]  <= pipe_tag[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Backing store is deliberately left uninitialised across reset.
    always_ff @(posedge clock) begin
        if (store_acc) begin
            mem[word_idx] <= proc2mem_data;
        end
    end

    assign mem2proc_tag  = pipe_tag[LATENCY-1];
    assign mem2proc_data = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder; a small tag/LFSR model predicts responses and queued returns.
module tb_mem_responder;
    localparam int LAT  = 4;
    localparam int MAXO = 4;
    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  proc2mem_command = NONE;
    logic [63:0] proc2mem_addr = 64'd0;
    logic [63:0] proc2mem_data = 64'd0;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    typedef struct {
        int          cyc;
        logic [3:0]  tag;
        logic [63:0] data;
    } ret_t;

    ret_t        sb [$];
    logic [63:0] shadow [int];
    bit          exp_busy [16];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    mem_responder #(.MEM_WORDS(4096), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    always #5 clock = ~clock;

`ifdef MEM_RESP_STALL_EN
    logic [15:0] ref_lfsr;
    always @(posedge clock) begin
        if (reset) ref_lfsr = 16'hACE1;
        else       ref_lfsr = {1'b0, ref_lfsr[15:1]} ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
    end
`endif

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [3:0] model_resp(input logic [1:0] cmd);
        if (cmd != LOAD && cmd != STORE) return 4'd0;
`ifdef MEM_RESP_STALL_EN
        if (ref_lfsr[2:0] == 3'b000) return 4'd0;
`endif
        for (int i = 1; i <= MAXO; i++) if (!exp_busy[i]) return 4'(i);
        return 4'd0;
    endfunction

    // One bus cycle: drive, predict, compare response and return port, update model.
    task automatic step(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data,
                        output logic [3:0] resp);
        logic [3:0] exp_r;
        int         idx;
        ret_t       e;
        proc2mem_command = cmd;
        proc2mem_addr    = addr;
        proc2mem_data    = data;
        @(negedge clock);
        idx   = int'(addr[14:3]);
        exp_r = model_resp(cmd);
        resp  = mem2proc_response;
        check("response", resp, exp_r);
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("ret_tag", mem2proc_tag, e.tag);
            check("ret_data", mem2proc_data, e.data);
            exp_busy[e.tag] = 1'b0;
        end else begin
            check("idle_tag", mem2proc_tag, 0);
            check("idle_data", mem2proc_data, 0);
        end
        if (exp_r != 4'd0) begin
            if (cmd == LOAD) begin
                exp_busy[exp_r] = 1'b1;
                e.cyc  = cyc + LAT;
                e.tag  = exp_r;
                e.data = shadow[idx];
                sb.push_back(e);
            end else begin
                shadow[idx] = data;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data,
                         output logic [3:0] tag, output int n);
        n = 0;
        do begin
            step(cmd, addr, data, tag);
            n++;
        end while (tag == 4'd0 && n < 40);
        check("accept_timeout", {63'd0, tag == 4'd0}, 64'd0);
    endtask

    task automatic idle(input int cycles);
        logic [3:0] r;
        for (int i = 0; i < cycles; i++) step(NONE, 64'd0, 64'd0, r);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        proc2mem_command = NONE;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_tag", mem2proc_tag, 0);
        check("rst_data", mem2proc_data, 0);
        sb.delete();
        for (int i = 0; i < 16; i++) exp_busy[i] = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] t;
        int         n;
        do_reset();
        for (int i = 0; i < 16; i++) issue(STORE, 64'(i * 8), 64'hC0DE_0000_0000_0000 | 64'(i), t, n);
        issue(STORE, 64'h40, 64'h1111, t, n);
        idle(2);

        issue(LOAD, 64'h40, 64'd0, t, n);
        check("t1_tag", t, 1);
        idle(LAT + 2);

        issue(STORE, 64'h80, 64'hABCD, t, n);
        check("t2_store_tag", t, 1);
        issue(LOAD, 64'h80, 64'd0, t, n);
        check("t2_load_tag", t, 1);
        idle(LAT + 2);

        // Fill every tag, then hold a load and later a store against the full set.
        for (int i = 0; i < MAXO; i++) issue(LOAD, 64'(i * 8), 64'd0, t, n);
        issue(LOAD, 64'h28, 64'd0, t, n);
`ifndef MEM_RESP_STALL_EN
        check("t3_retry_tag", t, 1);
        check("t3_retry_cnt", 64'(n), 2);
`endif
        idle(LAT + 2);
        for (int i = 0; i < MAXO; i++) issue(LOAD, 64'(i * 8 + 32), 64'd0, t, n);
        issue(STORE, 64'h18, 64'h5555_AAAA, t, n);
`ifndef MEM_RESP_STALL_EN
        check("t3_store_cnt", 64'(n), 2);
`endif
        idle(LAT + 2);
        issue(LOAD, 64'h18, 64'd0, t, n);
        idle(LAT + 2);

        issue(LOAD, 64'h0, 64'd0, t, n);
        issue(LOAD, 64'h8, 64'd0, t, n);
        issue(LOAD, 64'h10, 64'd0, t, n);
        idle(LAT + 2);

        issue(LOAD, 64'h20, 64'd0, t, n);
        issue(LOAD, 64'h28, 64'd0, t, n);
        issue(LOAD, 64'h30, 64'd0, t, n);
        do_reset();
        idle(LAT + 3);
        issue(LOAD, 64'h0, 64'd0, t, n);
        check("t5_post_reset_tag", t, 1);
        idle(LAT + 2);

        for (int i = 0; i < 40; i++) begin
            logic [63:0] a;
            a = 64'($urandom_range(0, 15)) << 3;
            if ($urandom_range(0, 2) == 0) issue(STORE, a, {$urandom, $urandom}, t, n);
            else                           issue(LOAD, a, 64'd0, t, n);
        end
        idle(LAT + 2);
        check("sb_drained", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
